// File: rtl/audio_codec_dac_serializer_if.sv
// Stereo sample handshake between a PCM producer and the DAC serializer.
// One transfer per AUD_XCK edge where sample_valid && sample_ready.
interface audio_codec_dac_serializer_if #(
   parameter int DW = 16
);
   logic [DW-1:0] left_in;
   logic [DW-1:0] right_in;
   logic          sample_valid;
   logic          sample_ready;

   modport master (
      output left_in,
      output right_in,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  left_in,
      input  right_in,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/audio_codec_dac_serializer.sv
// Left-justified WM8731 DAC serializer driven by external BCLK/LRCK.
// Buffers one stereo frame so the producer has a full LRCK period of slack.
module audio_codec_dac_serializer #(
   parameter int DW = 16
) (
   input  logic                        AUD_XCK,
   input  logic                        reset,
   input  logic                        AUD_BCLK,
   input  logic                        AUD_DACLRCK,
   audio_codec_dac_serializer_if.slave smp,
   output logic                        AUD_DACDAT,
   output logic                        underrun
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE,
      LEFT,
      RIGHT
   } state_t;

   state_t          state_q, state_d;
   logic            bclk_q, lrck_q;
   logic            pend_q, pend_d;
   logic [DW-1:0]   pend_l_q, pend_l_d;
   logic [DW-1:0]   pend_r_q, pend_r_d;
   logic [DW-1:0]   sh_q, sh_d;
   logic [DW-1:0]   rhold_q, rhold_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dat_q, dat_d;
   logic            ur_q, ur_d;
   logic            ready;
   logic            accept;
   logic            bclk_fall, lrck_rise, lrck_fall;

   // Edge history keeps tracking through reset so release never fakes an edge
   always_ff @(posedge AUD_XCK) begin
      bclk_q <= AUD_BCLK;
      lrck_q <= AUD_DACLRCK;
   end

   assign bclk_fall = bclk_q & ~AUD_BCLK;
   assign lrck_rise = ~lrck_q & AUD_DACLRCK;
   assign lrck_fall = lrck_q & ~AUD_DACLRCK;

   assign ready            = ~reset & ~pend_q;
   assign accept           = smp.sample_valid & ready;
   assign smp.sample_ready = ready;
   assign AUD_DACDAT       = dat_q;
   assign underrun         = ur_q;

   always_ff @(posedge AUD_XCK or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pend_q   <= 1'b0;
         pend_l_q <= '0;
         pend_r_q <= '0;
         sh_q     <= '0;
         rhold_q  <= '0;
         cnt_q    <= '0;
         dat_q    <= 1'b0;
         ur_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         pend_l_q <= pend_l_d;
         pend_r_q <= pend_r_d;
         sh_q     <= sh_d;
         rhold_q  <= rhold_d;
         cnt_q    <= cnt_d;
         dat_q    <= dat_d;
         ur_q     <= ur_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      pend_l_d = pend_l_q;
      pend_r_d = pend_r_q;
      sh_d     = sh_q;
      rhold_d  = rhold_q;
      cnt_d    = cnt_q;
      dat_d    = dat_q;
      ur_d     = 1'b0;

      if (accept) begin
         pend_d   = 1'b1;
         pend_l_d = smp.left_in;
         pend_r_d = smp.right_in;
      end

      // Load decisions see the slot as it was before this cycle's accept
      if (lrck_rise) begin
         state_d = LEFT;
         cnt_d   = CW'(1);
         if (pend_q) begin
            sh_d    = pend_l_q;
            rhold_d = pend_r_q;
            pend_d  = 1'b0;
            dat_d   = pend_l_q[DW-1];
         end else begin
            sh_d    = '0;
            rhold_d = '0;
            ur_d    = 1'b1;
            dat_d   = 1'b0;
         end
      end else if (lrck_fall) begin
         if (state_q != IDLE) begin
            state_d = RIGHT;
            sh_d    = rhold_q;
            dat_d   = rhold_q[DW-1];
            cnt_d   = CW'(1);
         end
      end else if (bclk_fall && state_q != IDLE) begin
         if (cnt_q < CW'(DW)) begin
            sh_d  = sh_q << 1;
            dat_d = sh_q[DW-2];
            cnt_d = cnt_q + CW'(1);
         end else begin
            dat_d = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_audio_codec_dac_serializer.sv
// Randomized bench: BCLK=XCK/4, LRCK=XCK/128, words captured on BCLK rise
// and compared with a queue-based model of the one-deep pending slot.
module tb_audio_codec_dac_serializer;

   localparam int DW = 16;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
   } frame_t;

   logic xck = 1'b0;
   logic reset = 1'b1;
   int   xc = 64;
   logic bclk, lrck;
   logic dacdat, underrun;

   int checks = 0;
   int errors = 0;

   audio_codec_dac_serializer_if #(.DW(DW)) smp ();

   audio_codec_dac_serializer #(.DW(DW)) dut (
      .AUD_XCK     (xck),
      .reset       (reset),
      .AUD_BCLK    (bclk),
      .AUD_DACLRCK (lrck),
      .smp         (smp),
      .AUD_DACDAT  (dacdat),
      .underrun    (underrun)
   );

   always #5 xck = ~xck;

   // Clock generator: BCLK_CYC=4, LRCK_CYC=128, LRCK edges on BCLK falls
   always @(posedge xck) xc <= (xc == 127) ? 0 : xc + 1;
   assign bclk = (xc % 4) >= 2;
   assign lrck = xc < 64;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   frame_t        q[$];
   frame_t        f;
   bit            active = 0;
   bit            half_ok = 0;
   bit            is_left = 0;
   bit            ur_exp = 0;
   logic [DW-1:0] exp_half = '0;
   logic [DW-1:0] rhold_m = '0;
   logic [DW-1:0] cap = '0;
   int            nbits = 0;
   logic          b1 = 1'b0, b2 = 1'b0, lprev = 1'b0;
   logic          dprev = 1'b0, rst_prev = 1'b1;

   always @(negedge xck) begin
      if (reset) begin
         q.delete();
         active  = 0;
         half_ok = 0;
         ur_exp  = 0;
      end else begin
         chk("ready", smp.sample_ready, q.size() == 0);
         chk("underrun", underrun, ur_exp);
         if (!rst_prev && dacdat !== dprev)
            chk("dat_timing", {b2, b1}, 2'b10);
         if (bclk && !b1) begin
            cap = {cap[DW-2:0], dacdat};
            nbits++;
         end
         ur_exp = 0;
         if (lrck != lprev) begin
            if (half_ok) begin
               chk(is_left ? "left_word" : "right_word", cap, exp_half);
               chk("bitcount", nbits, DW);
            end
            cap     = '0;
            nbits   = 0;
            half_ok = 1;
            if (lrck) begin
               active  = 1;
               is_left = 1;
               if (q.size() != 0) begin
                  f        = q.pop_front();
                  exp_half = f.l;
                  rhold_m  = f.r;
               end else begin
                  exp_half = '0;
                  rhold_m  = '0;
                  ur_exp   = 1;
               end
            end else begin
               is_left  = 0;
               exp_half = active ? rhold_m : '0;
            end
         end
         if (smp.sample_valid && smp.sample_ready) begin
            f.l = smp.left_in;
            f.r = smp.right_in;
            q.push_back(f);
         end
      end
      b2       = b1;
      b1       = bclk;
      lprev    = lrck;
      dprev    = dacdat;
      rst_prev = reset;
   end

   task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
      int n;
      smp.left_in      = l;
      smp.right_in     = r;
      smp.sample_valid = 1'b1;
      n = 0;
      do begin
         @(negedge xck);
         n++;
      end while (!smp.sample_ready && n < 2000);
      if (n >= 2000) chk("offer_timeout", 1, 0);
      @(posedge xck);
      #1;
   endtask

   task automatic wait_xc(input int v);
      int n;
      n = 0;
      do begin
         @(posedge xck);
         #1;
         n++;
      end while (xc != v && n < 300);
      if (n >= 300) chk("wait_timeout", 1, 0);
   endtask

   initial begin
      smp.sample_valid = 1'b0;
      smp.left_in      = '0;
      smp.right_in     = '0;
      repeat (3) @(posedge xck);
      #1;
      chk("rst_ready", smp.sample_ready, 0);
      chk("rst_dat", dacdat, 0);
      chk("rst_ur", underrun, 0);
      reset = 1'b0;
      #1;
      chk("rel_ready", smp.sample_ready, 1);

      // Known frame before the first left start
      offer(16'hA5F0, 16'h0F0F);
      smp.sample_valid = 1'b0;

      // Starvation: silence with one underrun per left frame
      repeat (3 * 128) @(posedge xck);
      #1;

      // Back-to-back samples with valid held high
      offer(16'd1, 16'd1);
      offer(16'd2, 16'd2);
      offer(16'd3, 16'd3);
      smp.sample_valid = 1'b0;
      repeat (3 * 128) @(posedge xck);
      #1;

      // Offer lands in the same cycle the serializer sees LRCK rise
      wait_xc(0);
      offer(16'h1357, 16'h2468);
      smp.sample_valid = 1'b0;
      repeat (3 * 128) @(posedge xck);
      #1;

      for (int k = 0; k < 14; k++) begin
         repeat ($urandom_range(0, 200)) @(posedge xck);
         #1;
         offer(DW'($urandom), DW'($urandom));
         smp.sample_valid = 1'b0;
      end
      repeat (2 * 128) @(posedge xck);
      #1;

      // Reset in the middle of the left word
      offer(16'hFFFF, 16'hFFFF);
      smp.sample_valid = 1'b0;
      wait_xc(0);
      wait_xc(3);
      offer(16'h1234, 16'h5678);
      smp.sample_valid = 1'b0;
      wait_xc(27);
      chk("pre_rst_dat", dacdat, 1);
      reset = 1'b1;
      #1;
      chk("async_rst_dat", dacdat, 0);
      repeat (10) @(posedge xck);
      #1;
      chk("mid_rst_ready", smp.sample_ready, 0);
      wait_xc(70);
      reset = 1'b0;
      repeat (2 * 128) @(posedge xck);
      #1;

      offer(16'h8001, 16'h7FFE);
      smp.sample_valid = 1'b0;
      repeat (2 * 128) @(posedge xck);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
